// File: rtl/flit_sel_mux.sv
// One-hot flit selector with a single output register and per-packet port locking.
// Latency 1 cycle; ready_o back-pressures the selected port when the output register is full and not draining.
module flit_sel_mux #(
    parameter int NUM_IN     = 5,
    parameter int DATA_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN-1:0]              sel,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   data_i,
    input  logic [NUM_IN-1:0]              valid_i,
    input  logic [NUM_IN-1:0]              tail_i,
    output logic [NUM_IN-1:0]              ready_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic                           valid_o,
    output logic                           tail_o,
    input  logic                           ready_i,
    output logic                           lock_o,
    output logic                           sel_err_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_IN-1:0]       r_lock_sel;
    logic [NUM_IN-1:0]       w_lock_sel_nxt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_tail;
    logic                    r_sel_err;

    logic                    w_onehot;
    logic                    w_sel_bad;
    logic [NUM_IN-1:0]       w_act_sel;
    logic                    w_out_ready;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_mux_data;
    logic                    w_mux_tail;

    assign w_onehot    = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign w_sel_bad   = (sel != '0) && !w_onehot;
    assign w_act_sel   = (r_state == LOCKED) ? r_lock_sel : (w_onehot ? sel : '0);
    assign w_out_ready = !r_valid || ready_i;
    assign ready_o     = rst ? '0 : (w_act_sel & {NUM_IN{w_out_ready}});
    assign w_xfer      = |(valid_i & ready_o);

    // act_sel is at most one-hot, so OR-reduction is a true mux.
    always_comb begin
        w_mux_data = '0;
        w_mux_tail = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (w_act_sel[k]) begin
                w_mux_data = w_mux_data | data_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_mux_tail = w_mux_tail | tail_i[k];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_sel_nxt = r_lock_sel;
        if (w_xfer) begin
            if (w_mux_tail) begin
                w_state_nxt    = IDLE;
                w_lock_sel_nxt = '0;
            end else if (r_state == IDLE) begin
                w_state_nxt    = LOCKED;
                w_lock_sel_nxt = w_act_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_sel <= w_lock_sel_nxt;
        end
    end

    // Output stage: load on transfer, otherwise drain; payload holds after drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_tail    <= 1'b0;
            r_valid   <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= (r_state == IDLE) && w_sel_bad;
            if (w_xfer) begin
                r_data  <= w_mux_data;
                r_tail  <= w_mux_tail;
                r_valid <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign tail_o    = r_tail;
    assign lock_o    = (r_state == LOCKED);
    assign sel_err_o = r_sel_err;

endmodule

// File: doc/flit_sel_mux.md
FLIT_SEL_MUX -- requirements
Module: flit_sel_mux

Interface
REQ-001 Parameters SHALL be:
- NUM_IN, default 5, number of one-hot-selected input ports (2..16).
- DATA_WIDTH, default 4, flit payload width.

REQ-002 Ports SHALL be, in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  NUM_IN  one-hot input select.
- data_i  in  NUM_IN*DATA_WIDTH  packed payloads; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_i  in  NUM_IN  per-port flit valid.
- tail_i  in  NUM_IN  per-port tail-flit marker.
- ready_o  out  NUM_IN  per-port flit accepted this cycle.
- data_o  out  DATA_WIDTH  registered output payload.
- valid_o  out  1  output register holds a flit.
- tail_o  out  1  held flit is a tail.
- ready_i  in  1  downstream accepts the held flit.
- lock_o  out  1  port selection is locked mid-packet.
- sel_err_o  out  1  one-cycle pulse on an illegal select.

Function
REQ-003 The block SHALL have one output register stage; an accepted input flit appears on data_o/valid_o/tail_o exactly 1 cycle after acceptance.
REQ-004 out_ready SHALL equal (!valid_o | ready_i); the output stage SHALL accept a new flit and release the held flit in the same cycle.
REQ-005 FSM states SHALL be IDLE and LOCKED, and the effective select act_sel SHALL be:
- IDLE: sel when sel is exactly one-hot, otherwise 0.
- LOCKED: the registered lock_sel; sel is ignored.
REQ-006 ready_o[k] SHALL equal act_sel[k] & out_ready; at most one ready_o bit SHALL ever be high.
REQ-007 A transfer SHALL occur when valid_i[k] & ready_o[k]; the output register then loads data_i port k, tail_i[k], and valid_o=1.
REQ-008 When valid_o & ready_i and no transfer occurs, valid_o SHALL clear to 0; data_o and tail_o SHALL hold their values.
REQ-009 IDLE->LOCKED SHALL occur on a non-tail transfer, with lock_sel loaded from act_sel.
REQ-010 LOCKED->IDLE SHALL occur on a tail transfer; lock_sel SHALL clear to 0.
REQ-011 A tail transfer in IDLE (single-flit packet) SHALL keep the state IDLE.
REQ-012 lock_o SHALL be high exactly when the state is LOCKED.
REQ-013 sel_err_o SHALL be registered, high for one cycle after an IDLE cycle in which sel is nonzero and not one-hot.
REQ-014 sel==0 in IDLE SHALL be a legal idle condition: no transfer and no error.
REQ-015 valid_i on unselected ports SHALL be ignored; their flits SHALL never be dropped, duplicated or reordered by this block.
REQ-016 If the output is full and ready_i=0, ready_o SHALL be all-zero and all state SHALL hold, including LOCKED.

Reset
REQ-017 While rst is high at a clock edge:
- state, lock_sel, data_o, tail_o, valid_o and sel_err_o SHALL clear to 0 (state=IDLE).
- ready_o SHALL be forced to 0 combinationally.
REQ-018 A reset asserted mid-packet SHALL abandon the lock and discard the held flit; the first cycle after reset SHALL behave as IDLE.

Verification
REQ-019 Single flit: sel=5'b00100, valid_i[2]=1, tail_i[2]=1, data port2=4'hA, ready_i=1 -> ready_o=5'b00100 in cycle 0; data_o=4'hA, valid_o=1, tail_o=1 in cycle 1; lock_o stays 0.
REQ-020 Packet lock: 3-flit packet on port 1 (4'h1, 4'h2, 4'h3 with tail), sel changed to 5'b01000 after the head -> lock_o=1 for 2 cycles; all three flits come out in order from port 1; port 3 is selected only after the tail.
REQ-021 Backpressure: ready_i=0 with valid_o=1 for 4 cycles -> ready_o=0, data_o held; ready_i=1 -> held flit released and next flit loaded in the same cycle, with no bubble.
REQ-022 Illegal select: sel=5'b00110 in IDLE -> ready_o=0, no transfer, sel_err_o=1 for exactly one cycle; sel=5'b00000 -> no error.
REQ-023 Reset mid-packet: rst=1 while LOCKED on port 4 with valid_o=1 -> next cycle valid_o=0, lock_o=0; a new head on port 0 is accepted immediately after rst falls.
